// File: rtl/partition_error_monitor.sv
// Windowed mismatch statistics for an approximate partition output versus its exact reference.
// Define PARTITION_MON_MAXERR_EN to build the max |approx-exact| tracker; without it max_err is tied to 0.

module partition_error_lane (
  input  logic a,
  input  logic e,
  output logic mis
);
  assign mis = a ^ e;
endmodule

module partition_error_monitor #(
  parameter  int W         = 4,
  parameter  int N_SAMPLES = 256,
  parameter  int CNT_W     = 16,
  localparam int HS_W      = CNT_W + $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     approx,
  input  logic [W-1:0]     exact,
  output logic             res_valid,
  input  logic             res_ack,
  output logic             busy,
  output logic [CNT_W-1:0] err_cnt,
  output logic [HS_W-1:0]  ham_sum,
  output logic [W-1:0]     max_err
);
  localparam int PC_W = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [W-1:0]     mis;
  logic [PC_W-1:0]  pop;
  logic [CNT_W-1:0] smp_cnt;
  logic             beat, last, clr;

  for (genvar i = 0; i < W; i++) begin : g_lane
    partition_error_lane u_lane (.a(approx[i]), .e(exact[i]), .mis(mis[i]));
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < W; i++) pop = pop + PC_W'(mis[i]);
  end

  assign beat = in_valid & in_ready;
  assign last = (smp_cnt == CNT_W'(N_SAMPLES - 1));
  assign clr  = (state == IDLE) & start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)        state_nxt = RUN;
      RUN:     if (beat && last) state_nxt = DONE;
      DONE:    if (res_ack)      state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // Handshake outputs depend on registered state only.
  always_comb begin
    in_ready  = (state == RUN);
    res_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_cnt <= '0;
      err_cnt <= '0;
      ham_sum <= '0;
    end else if (clr) begin
      smp_cnt <= '0;
      err_cnt <= '0;
      ham_sum <= '0;
    end else if (beat) begin
      smp_cnt <= smp_cnt + 1'b1;
      err_cnt <= err_cnt + CNT_W'(|mis);
      ham_sum <= ham_sum + HS_W'(pop);
    end
  end

`ifdef PARTITION_MON_MAXERR_EN
  logic [W-1:0] abs_diff, max_q;

  assign abs_diff = (approx >= exact) ? (approx - exact) : (exact - approx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           max_q <= '0;
    else if (clr)                         max_q <= '0;
    else if (beat && (abs_diff > max_q))  max_q <= abs_diff;
  end

  assign max_err = max_q;
`else
  assign max_err = '0;
`endif

endmodule

// File: doc/partition_error_monitor.md
# partition_error_monitor

Sequential error-statistics stage that sits directly downstream of an approximate adder partition (BMF-factored output stage, e.g. 4 outputs reconstructed from one latent bit). Each cycle it consumes the approximate partition output together with the exact reference output and accumulates mismatch statistics over a fixed window of samples. At the end of the window it presents the results for the design-space-exploration flow to score the approximation.

## Interface
- `W`, default 4: width of the partition output vector being scored.
- `N_SAMPLES`, default 256: number of accepted beats per measurement window. Must be ≥1 and < 2^CNT_W.
- `CNT_W`, default 16: width of the sample and error counters.
- `HS_W`, derived as CNT_W + clog2(W+1), not overridable: width of the Hamming sum.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: begin a window. Honoured only in IDLE.
- `in_valid`, input, 1: approx/exact sample is valid.
- `in_ready`, output, 1: monitor accepts a sample this cycle.
- `approx`, input, W: approximate partition output (po vector).
- `exact`, input, W: exact reference output for the same operands.
- `res_valid`, output, 1: window results are valid and held stable.
- `res_ack`, input, 1: consumer has taken the results.
- `busy`, output, 1: high in RUN or DONE.
- `err_cnt`, output, CNT_W: number of beats with approx ≠ exact.
- `ham_sum`, output, HS_W: sum over beats of popcount(approx ^ exact).
- `max_err`, output, W: maximum unsigned |approx − exact| (see Configuration).

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=0, res_valid=0.
  - `start` → RUN. On the same edge, clear the sample counter, err_cnt, ham_sum and max_err.
- RUN:
  - in_ready=1.
  - Beat = in_valid & in_ready.
  - Each beat: sample counter +1; err_cnt += (approx≠exact); ham_sum += popcount(approx^exact); max_err = max(max_err, |approx−exact|).
  - The beat that brings the sample counter to N_SAMPLES transitions to DONE. Its contribution is included.
  - in_valid low: no change.
- DONE:
  - res_valid=1, in_ready=0. All result outputs are frozen.
  - `res_ack` → IDLE. Results keep their values in IDLE until the next `start` clears them.
- `start` in RUN or DONE is ignored. `start` and `res_ack` together in DONE → IDLE only; `start` must be re-issued.
- Arithmetic:
  - |approx−exact| is computed as unsigned magnitude in W bits.
  - popcount result is clog2(W+1) bits, zero-extended before accumulation.
  - Counters cannot overflow given the N_SAMPLES constraint. No saturation logic.
- Reset mid-window (rst_n low in any state): immediate return to IDLE, all outputs 0, partial statistics discarded.

## Timing
- Reset values: in_ready=0, res_valid=0, busy=0, err_cnt=0, ham_sum=0, max_err=0.
- in_ready, res_valid and busy are decoded from registered state only. No combinational path from in_valid, start or res_ack to any output.
- Latency: the final beat is accepted in cycle t. In cycle t+1: res_valid=1, in_ready=0, and the outputs include the final beat.
- Minimum window duration: start edge, then N_SAMPLES cycles in RUN with in_valid held high, then DONE.
- Throughput: one sample per cycle in RUN.
- Back-to-back windows: at least one IDLE cycle between res_ack and the next accepted start.

## Configuration
- `PARTITION_MON_MAXERR_EN`:
  - Defined: the max_err register and the W-bit subtract/compare path are compiled in, behaving as described above.
  - Undefined: no max_err logic is instantiated and max_err is tied to 0 at all times. err_cnt, ham_sum and the FSM are unaffected.

## Test plan
- Reset mid-RUN: W=4, N_SAMPLES=4. Start, feed 2 mismatching beats, pulse rst_n low → all outputs 0, state IDLE, no res_valid.
- All-match window: 4 beats with approx=exact=4'h5 → res_valid one cycle after 4th beat; err_cnt=0, ham_sum=0, max_err=0.
- Mixed window: beats (approx,exact) = (8,0), (0,0), (3,0), (F,1) → err_cnt=3, ham_sum=1+0+2+3=6, max_err=14 (macro defined) / 0 (undefined).
- Backpressure-free gaps: the same 4 beats with in_valid low on alternate cycles → identical results; res_valid exactly one cycle after the 4th accepted beat.
- Handshake corners:
  - start asserted during RUN and during DONE → ignored, window length unchanged.
  - start and res_ack together in DONE → IDLE, no new window begins.
  - Results stay frozen while res_ack is held low for 10 cycles.
- Full-width case: N_SAMPLES=255, CNT_W=8, every beat approx=F, exact=0 → err_cnt=255, ham_sum=1020, max_err=15, no overflow.
